// File: rtl/alu_hilo_seq_muldiv_if.sv
// Issue / move-to / result bundle between decode-EX and the HI/LO multiply-divide engine.
interface alu_hilo_seq_muldiv_if #(parameter int DATA_W = 32);
    logic              start;
    logic [1:0]        op;
    logic [DATA_W-1:0] data1;
    logic [DATA_W-1:0] data2;
    logic              wr_hi;
    logic              wr_lo;
    logic [DATA_W-1:0] wr_data;
    logic              busy;
    logic              done;
    logic              divz;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;

    modport master (
        output start, op, data1, data2, wr_hi, wr_lo, wr_data,
        input  busy, done, divz, hi, lo
    );

    modport slave (
        input  start, op, data1, data2, wr_hi, wr_lo, wr_data,
        output busy, done, divz, hi, lo
    );
endinterface

// File: rtl/alu_hilo_seq_muldiv.sv
// Radix-2 iterative multiply/divide engine owning the architectural HI/LO pair.
// The divide datapath is present only when ALU_HILO_SEQ_DIV_EN is defined.
module alu_hilo_seq_muldiv #(
    parameter int DATA_W = 32
) (
    input  logic                 clock,
    input  logic                 reset_n,
    alu_hilo_seq_muldiv_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2, FIX = 2'd3} state_t;

    localparam logic [DATA_W-1:0]   ZERO_W   = {DATA_W{1'b0}};
    localparam logic [DATA_W-1:0]   ONE_W    = DATA_W'(1);
    localparam logic [DATA_W-1:0]   CNT_INIT = DATA_W'(DATA_W - 1);
    localparam logic [2*DATA_W-1:0] ONE_2W   = (2*DATA_W)'(1);

    state_t              state_r;
    logic [1:0]          op_r;
    logic                sgn1_r;
    logic                sgn2_r;
    logic [DATA_W-1:0]   opa_r;
    logic [DATA_W-1:0]   opb_r;
    logic [2*DATA_W-1:0] acc_r;
    logic [DATA_W-1:0]   cnt_r;
    logic [DATA_W-1:0]   hi_r;
    logic [DATA_W-1:0]   lo_r;
    logic                busy_r;
    logic                done_r;
    logic                divz_r;

    logic [DATA_W:0]     mul_sum_s;
    logic [2*DATA_W-1:0] mul_next_s;
    logic [2*DATA_W-1:0] prod_s;
    logic [DATA_W-1:0]   res_hi_s;
    logic [DATA_W-1:0]   res_lo_s;
    logic                res_wr_s;
    logic                res_dz_s;
`ifdef ALU_HILO_SEQ_DIV_EN
    logic [DATA_W:0]     rem_sh_s;
    logic [DATA_W+1:0]   diff_s;
    logic [2*DATA_W-1:0] div_next_s;
`endif

    function automatic logic [DATA_W-1:0] neg_w(input logic [DATA_W-1:0] v, input logic en);
        if (en) neg_w = ~v + ONE_W;
        else    neg_w = v;
    endfunction

    function automatic logic [2*DATA_W-1:0] neg_2w(input logic [2*DATA_W-1:0] v, input logic en);
        if (en) neg_2w = ~v + ONE_2W;
        else    neg_2w = v;
    endfunction

    // Single-step datapath for shift-add / restoring divide, plus sign-fixed final results.
    always_comb begin
        mul_sum_s = {1'b0, acc_r[2*DATA_W-1:DATA_W]};
        if (acc_r[0]) mul_sum_s = {1'b0, acc_r[2*DATA_W-1:DATA_W]} + {1'b0, opa_r};
        else          mul_sum_s = {1'b0, acc_r[2*DATA_W-1:DATA_W]};
        mul_next_s = {mul_sum_s, acc_r[DATA_W-1:1]};
        prod_s     = neg_2w(acc_r, sgn1_r ^ sgn2_r);
        res_hi_s   = prod_s[2*DATA_W-1:DATA_W];
        res_lo_s   = prod_s[DATA_W-1:0];
        res_wr_s   = 1'b1;
        res_dz_s   = 1'b0;
`ifdef ALU_HILO_SEQ_DIV_EN
        // Partial remainder shifted left with the next dividend bit; a clear top bit of diff means it fits.
        rem_sh_s = {acc_r[2*DATA_W-1:DATA_W], acc_r[DATA_W-1]};
        diff_s   = {1'b0, rem_sh_s} - {2'b00, opb_r};
        if (!diff_s[DATA_W+1]) div_next_s = {diff_s[DATA_W-1:0], acc_r[DATA_W-2:0], 1'b1};
        else                   div_next_s = {rem_sh_s[DATA_W-1:0], acc_r[DATA_W-2:0], 1'b0};
        if (op_r[1]) begin
            if (opb_r == ZERO_W) begin
                res_hi_s = neg_w(opa_r, sgn1_r);
                res_lo_s = {DATA_W{1'b1}};
                res_dz_s = 1'b1;
            end else begin
                res_hi_s = neg_w(acc_r[2*DATA_W-1:DATA_W], sgn1_r);
                res_lo_s = neg_w(acc_r[DATA_W-1:0], sgn1_r ^ sgn2_r);
                res_dz_s = 1'b0;
            end
        end else begin
            res_dz_s = 1'b0;
        end
`else
        if (op_r[1]) res_wr_s = 1'b0;
        else         res_wr_s = 1'b1;
`endif
    end

    // Control FSM, operand/accumulator state and the architectural HI/LO registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            op_r    <= 2'b00;
            sgn1_r  <= 1'b0;
            sgn2_r  <= 1'b0;
            opa_r   <= ZERO_W;
            opb_r   <= ZERO_W;
            acc_r   <= {2*DATA_W{1'b0}};
            cnt_r   <= ZERO_W;
            hi_r    <= ZERO_W;
            lo_r    <= ZERO_W;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            divz_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (!busy_r) begin
                if (bus.wr_hi) hi_r <= bus.wr_data;
                if (bus.wr_lo) lo_r <= bus.wr_data;
            end
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        op_r   <= bus.op;
                        sgn1_r <= bus.op[0] & bus.data1[DATA_W-1];
                        sgn2_r <= bus.op[0] & bus.data2[DATA_W-1];
                        opa_r  <= neg_w(bus.data1, bus.op[0] & bus.data1[DATA_W-1]);
                        opb_r  <= neg_w(bus.data2, bus.op[0] & bus.data2[DATA_W-1]);
                        divz_r <= 1'b0;
`ifdef ALU_HILO_SEQ_DIV_EN
                        busy_r  <= 1'b1;
                        state_r <= LOAD;
`else
                        // Divides are acknowledged without running: straight to FIX with busy low.
                        if (bus.op[1]) begin
                            state_r <= FIX;
                        end else begin
                            busy_r  <= 1'b1;
                            state_r <= LOAD;
                        end
`endif
                    end
                end
                LOAD: begin
                    if (op_r[1]) acc_r <= {ZERO_W, opa_r};
                    else         acc_r <= {ZERO_W, opb_r};
                    cnt_r   <= CNT_INIT;
                    state_r <= RUN;
                end
                RUN: begin
`ifdef ALU_HILO_SEQ_DIV_EN
                    if (op_r[1]) acc_r <= div_next_s;
                    else         acc_r <= mul_next_s;
`else
                    acc_r <= mul_next_s;
`endif
                    if (cnt_r == ZERO_W) state_r <= FIX;
                    else                 cnt_r   <= cnt_r - ONE_W;
                end
                FIX: begin
                    if (res_wr_s) begin
                        hi_r <= res_hi_s;
                        lo_r <= res_lo_s;
                    end
                    divz_r  <= res_dz_s;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b1;
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.divz = divz_r;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;
endmodule

// File: tb/tb_alu_hilo_seq_muldiv.sv
// Directed bench for alu_hilo_seq_muldiv at DATA_W=4; divide vectors run when ALU_HILO_SEQ_DIV_EN is defined.
module tb_alu_hilo_seq_muldiv;
    logic clock;
    logic reset_n;
    int   total;
    int   bad;

    alu_hilo_seq_muldiv_if #(.DATA_W(4)) bus();

    alu_hilo_seq_muldiv #(.DATA_W(4)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Issue one op (now=1 drives start in the current cycle); returns edges-after-E until done and busy cycles seen.
    task automatic do_op(input bit now, input logic [1:0] o, input logic [3:0] a, input logic [3:0] b,
                         output int lat, output int bcnt);
        if (!now) @(negedge clock);
        bus.start = 1'b1; bus.op = o; bus.data1 = a; bus.data2 = b;
        @(negedge clock);
        bus.start = 1'b0;
        lat = 0; bcnt = 0;
        while (bus.done !== 1'b1 && lat < 20) begin
            if (bus.busy === 1'b1) bcnt++;
            @(negedge clock);
            lat++;
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.op = 2'd0; bus.data1 = 4'h0; bus.data2 = 4'h0;
        bus.wr_hi = 1'b0; bus.wr_lo = 1'b0; bus.wr_data = 4'h0;
        reset_n = 1'b0;
        #12;
        total++; if ({bus.hi, bus.lo} !== 8'h00) begin bad++; $display("FAIL reset_hilo got=%h exp=%h", {bus.hi, bus.lo}, 8'h00); end
        total++; if ({bus.busy, bus.done, bus.divz} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=%b", {bus.busy, bus.done, bus.divz}, 3'b000); end
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_multu();
        int lat, bcnt;
        do_op(1'b0, 2'd0, 4'hA, 4'hA, lat, bcnt);
        total++; if (lat !== 6) begin bad++; $display("FAIL multu_latency got=%0d exp=%0d", lat, 6); end
        total++; if (bcnt !== 6) begin bad++; $display("FAIL multu_busy_cycles got=%0d exp=%0d", bcnt, 6); end
        total++; if ({bus.hi, bus.lo} !== 8'h64) begin bad++; $display("FAIL multu_a_a got=%h exp=%h", {bus.hi, bus.lo}, 8'h64); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL multu_busy_at_done got=%b exp=%b", bus.busy, 1'b0); end
        @(negedge clock);
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL multu_done_pulse got=%b exp=%b", bus.done, 1'b0); end
        do_op(1'b0, 2'd0, 4'hF, 4'hF, lat, bcnt);
        total++; if ({bus.hi, bus.lo} !== 8'hE1) begin bad++; $display("FAIL multu_f_f got=%h exp=%h", {bus.hi, bus.lo}, 8'hE1); end
    endtask

    task automatic test_mult();
        int lat, bcnt;
        do_op(1'b0, 2'd1, 4'hD, 4'h3, lat, bcnt);
        total++; if ({bus.hi, bus.lo} !== 8'hF7) begin bad++; $display("FAIL mult_neg3_3 got=%h exp=%h", {bus.hi, bus.lo}, 8'hF7); end
        do_op(1'b0, 2'd1, 4'h8, 4'h8, lat, bcnt);
        total++; if ({bus.hi, bus.lo} !== 8'h40) begin bad++; $display("FAIL mult_neg8_neg8 got=%h exp=%h", {bus.hi, bus.lo}, 8'h40); end
        do_op(1'b0, 2'd1, 4'h8, 4'hF, lat, bcnt);
        total++; if ({bus.hi, bus.lo} !== 8'h08) begin bad++; $display("FAIL mult_neg8_neg1 got=%h exp=%h", {bus.hi, bus.lo}, 8'h08); end
    endtask

`ifdef ALU_HILO_SEQ_DIV_EN
    task automatic test_div();
        int lat, bcnt;
        do_op(1'b0, 2'd3, 4'h9, 4'h2, lat, bcnt);
        total++; if ({bus.hi, bus.lo} !== 8'hFD) begin bad++; $display("FAIL div_neg7_2 got=%h exp=%h", {bus.hi, bus.lo}, 8'hFD); end
        do_op(1'b0, 2'd2, 4'h7, 4'h3, lat, bcnt);
        total++; if ({bus.hi, bus.lo, bus.divz} !== 9'b0001_0010_0) begin bad++; $display("FAIL divu_7_3 got=%b exp=%b", {bus.hi, bus.lo, bus.divz}, 9'b0001_0010_0); end
        do_op(1'b0, 2'd2, 4'h5, 4'h0, lat, bcnt);
        total++; if (lat !== 6) begin bad++; $display("FAIL divz_latency got=%0d exp=%0d", lat, 6); end
        total++; if ({bus.hi, bus.lo, bus.divz} !== 9'b0101_1111_1) begin bad++; $display("FAIL divu_5_0 got=%b exp=%b", {bus.hi, bus.lo, bus.divz}, 9'b0101_1111_1); end
        @(negedge clock);
        bus.start = 1'b1; bus.op = 2'd0; bus.data1 = 4'h1; bus.data2 = 4'h1;
        @(negedge clock);
        bus.start = 1'b0;
        total++; if (bus.divz !== 1'b0) begin bad++; $display("FAIL divz_clear got=%b exp=%b", bus.divz, 1'b0); end
        repeat (6) @(negedge clock);
        do_op(1'b0, 2'd3, 4'h8, 4'hF, lat, bcnt);
        total++; if ({bus.hi, bus.lo, bus.divz} !== 9'b0000_1000_0) begin bad++; $display("FAIL div_overflow got=%b exp=%b", {bus.hi, bus.lo, bus.divz}, 9'b0000_1000_0); end
        do_op(1'b0, 2'd3, 4'h9, 4'h0, lat, bcnt);
        total++; if ({bus.hi, bus.lo, bus.divz} !== 9'b1001_1111_1) begin bad++; $display("FAIL div_signed_by_zero got=%b exp=%b", {bus.hi, bus.lo, bus.divz}, 9'b1001_1111_1); end
    endtask
`else
    task automatic test_nodiv();
        int lat, bcnt;
        do_op(1'b0, 2'd0, 4'h3, 4'h5, lat, bcnt);
        total++; if ({bus.hi, bus.lo} !== 8'h0F) begin bad++; $display("FAIL nodiv_setup got=%h exp=%h", {bus.hi, bus.lo}, 8'h0F); end
        do_op(1'b0, 2'd2, 4'h7, 4'h3, lat, bcnt);
        total++; if (lat !== 1) begin bad++; $display("FAIL nodiv_latency got=%0d exp=%0d", lat, 1); end
        total++; if (bcnt !== 0) begin bad++; $display("FAIL nodiv_busy got=%0d exp=%0d", bcnt, 0); end
        total++; if ({bus.hi, bus.lo, bus.divz} !== 9'b0000_1111_0) begin bad++; $display("FAIL nodiv_hilo_kept got=%b exp=%b", {bus.hi, bus.lo, bus.divz}, 9'b0000_1111_0); end
        @(negedge clock);
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL nodiv_done_pulse got=%b exp=%b", bus.done, 1'b0); end
    endtask
`endif

    task automatic test_moveto();
        int n;
        @(negedge clock); bus.wr_hi = 1'b1; bus.wr_data = 4'h3;
        @(negedge clock); bus.wr_hi = 1'b0;
        total++; if (bus.hi !== 4'h3) begin bad++; $display("FAIL mthi got=%h exp=%h", bus.hi, 4'h3); end
        bus.wr_lo = 1'b1; bus.wr_data = 4'h5;
        @(negedge clock); bus.wr_lo = 1'b0;
        total++; if ({bus.hi, bus.lo} !== 8'h35) begin bad++; $display("FAIL mtlo got=%h exp=%h", {bus.hi, bus.lo}, 8'h35); end
        bus.wr_hi = 1'b1; bus.wr_lo = 1'b1; bus.wr_data = 4'hA;
        @(negedge clock); bus.wr_hi = 1'b0; bus.wr_lo = 1'b0;
        total++; if ({bus.hi, bus.lo} !== 8'hAA) begin bad++; $display("FAIL mthi_mtlo got=%h exp=%h", {bus.hi, bus.lo}, 8'hAA); end
        bus.start = 1'b1; bus.op = 2'd0; bus.data1 = 4'h2; bus.data2 = 4'h3;
        bus.wr_lo = 1'b1; bus.wr_data = 4'hC;
        @(negedge clock); bus.start = 1'b0; bus.wr_lo = 1'b0;
        total++; if (bus.lo !== 4'hC) begin bad++; $display("FAIL mtlo_with_start got=%h exp=%h", bus.lo, 4'hC); end
        bus.wr_hi = 1'b1; bus.wr_data = 4'h9;
        @(negedge clock); @(negedge clock); bus.wr_hi = 1'b0;
        total++; if (bus.hi !== 4'hA) begin bad++; $display("FAIL mthi_dropped_busy got=%h exp=%h", bus.hi, 4'hA); end
        n = 0;
        while (bus.done !== 1'b1 && n < 20) begin @(negedge clock); n++; end
        total++; if ({bus.done, bus.hi, bus.lo} !== 9'b1_0000_0110) begin bad++; $display("FAIL moveto_overwritten got=%b exp=%b", {bus.done, bus.hi, bus.lo}, 9'b1_0000_0110); end
    endtask

    task automatic test_back_to_back();
        int lat, bcnt;
        do_op(1'b0, 2'd0, 4'h3, 4'h5, lat, bcnt);
        total++; if ({bus.hi, bus.lo} !== 8'h0F) begin bad++; $display("FAIL b2b_first got=%h exp=%h", {bus.hi, bus.lo}, 8'h0F); end
        do_op(1'b1, 2'd1, 4'h7, 4'h7, lat, bcnt);
        total++; if (lat !== 6) begin bad++; $display("FAIL b2b_latency got=%0d exp=%0d", lat, 6); end
        total++; if ({bus.hi, bus.lo} !== 8'h31) begin bad++; $display("FAIL b2b_second got=%h exp=%h", {bus.hi, bus.lo}, 8'h31); end
    endtask

    task automatic test_reset_mid();
        int pulses;
        @(negedge clock);
        bus.start = 1'b1; bus.op = 2'd0; bus.data1 = 4'hF; bus.data2 = 4'hF;
        @(negedge clock); bus.start = 1'b0;
        @(negedge clock); @(negedge clock);
        reset_n = 1'b0;
        #1;
        total++; if ({bus.busy, bus.hi, bus.lo} !== 9'b0_0000_0000) begin bad++; $display("FAIL reset_mid_op got=%b exp=%b", {bus.busy, bus.hi, bus.lo}, 9'b0_0000_0000); end
        @(negedge clock); reset_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (bus.done === 1'b1) pulses++;
        end
        total++; if (pulses !== 0) begin bad++; $display("FAIL reset_no_done got=%0d exp=%0d", pulses, 0); end
        total++; if ({bus.hi, bus.lo} !== 8'h00) begin bad++; $display("FAIL reset_no_partial got=%h exp=%h", {bus.hi, bus.lo}, 8'h00); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_multu();
        test_mult();
`ifdef ALU_HILO_SEQ_DIV_EN
        test_div();
`else
        test_nodiv();
`endif
        test_moveto();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
